// File: rtl/zeta_addr_gen.sv
// zeta_addr_gen
//   Generates the stage-ROM zeta indices for one NTT stage. A polynomial is
//   streamed as 2^BEAT_W beats; each beat carries two butterflies (lane 0
//   serves butterfly k, lane 1 serves butterfly k + 2^BEAT_W). The ROM holds
//   2^STAGE zetas for this stage, so the index is the top STAGE bits of the
//   butterfly number. Inverse ordering mirrors the index inside the ROM.
//
// Handshake: a beat is accepted when in_valid && in_ready; in_ready is simply
//   !stall and does not depend on in_valid, so no combinational loop can form.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream beat handshake
//   stall                downstream hold request (drops in_ready)
//   inv                  inverse ordering, captured on beat 0 only
//   rom_addr0/1          registered lane-0/1 zeta indices (STAGE bits)
//   addr_valid           rom_addr0/1 carry a beat issued last cycle
//   zeta_valid           ROM data valid (addr_valid delayed one cycle)
//   poly_last            zeta_valid belongs to the final beat of a polynomial
//   busy                 a polynomial is partially issued (state == RUN)

`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 7
`endif

module zeta_addr_gen #(
  parameter int STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             inv,
  output logic [STAGE-1:0] rom_addr0,
  output logic [STAGE-1:0] rom_addr1,
  output logic             addr_valid,
  output logic             zeta_valid,
  output logic             poly_last,
  output logic             busy
);

  localparam int BEAT_W = `NTT_STAGE_CNT - 1;
  localparam int CNT_W  = (BEAT_W > 0) ? BEAT_W : 1;
  localparam int SHIFT  = `NTT_STAGE_CNT - STAGE;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((1 << BEAT_W) - 1);
  localparam logic [STAGE-1:0] HALF      = STAGE'(1 << (STAGE - 1));
  localparam logic [STAGE-1:0] MAXA      = {STAGE{1'b1}};

  if (STAGE < 1 || STAGE > `NTT_STAGE_CNT - 1) begin : g_bad_stage
    $error("zeta_addr_gen: STAGE must be in 1..NTT_STAGE_CNT-1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inv_q, inv_d;
  logic [STAGE-1:0] rom_addr0_q, rom_addr0_d;
  logic [STAGE-1:0] rom_addr1_q, rom_addr1_d;
  logic             addr_valid_q, addr_valid_d;
  logic             addr_last_q, addr_last_d;
  logic             zeta_valid_q, zeta_valid_d;
  logic             poly_last_q, poly_last_d;

  logic             accept;
  logic [CNT_W-1:0] beat_k;
  logic             inv_use;
  logic [STAGE-1:0] f0, f1;

  assign in_ready = !stall;
  assign accept   = in_valid & in_ready;

  // Next-state: beat number and inverse flag for the beat offered this cycle.
  // Beat 0 uses the live inv input so the new ordering applies immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    beat_k  = cnt_q;
    inv_use = inv_q;
    case (state_q)
      IDLE: begin
        beat_k  = '0;
        inv_use = inv;
        if (accept) begin
          inv_d   = inv;
          cnt_d   = '0;
          state_d = (BEAT_W == 0) ? IDLE : RUN;
        end
      end
      RUN: begin
        beat_k = cnt_q + 1'b1;
        if (accept) begin
          cnt_d = beat_k;
          if (beat_k == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Index arithmetic: lane 0 takes the top STAGE bits of k; lane 1 sits half
  // a ROM further on. Inverse ordering reflects each index.
  always_comb begin
    f0           = STAGE'(beat_k >> SHIFT);
    f1           = f0 + HALF;
    rom_addr0_d  = rom_addr0_q;
    rom_addr1_d  = rom_addr1_q;
    addr_valid_d = accept;
    addr_last_d  = accept & (beat_k == LAST_BEAT);
    zeta_valid_d = addr_valid_q;
    poly_last_d  = addr_valid_q & addr_last_q;
    if (accept) begin
      rom_addr0_d = inv_use ? (MAXA - f0) : f0;
      rom_addr1_d = inv_use ? (MAXA - f1) : f1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      inv_q        <= 1'b0;
      rom_addr0_q  <= '0;
      rom_addr1_q  <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
      zeta_valid_q <= 1'b0;
      poly_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inv_q        <= inv_d;
      rom_addr0_q  <= rom_addr0_d;
      rom_addr1_q  <= rom_addr1_d;
      addr_valid_q <= addr_valid_d;
      addr_last_q  <= addr_last_d;
      zeta_valid_q <= zeta_valid_d;
      poly_last_q  <= poly_last_d;
    end
  end

  assign rom_addr0  = rom_addr0_q;
  assign rom_addr1  = rom_addr1_q;
  assign addr_valid = addr_valid_q;
  assign zeta_valid = zeta_valid_q;
  assign poly_last  = poly_last_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_zeta_addr_gen.sv
// Testbench for zeta_addr_gen: STAGE=3 and STAGE=1 instances share one
// stimulus stream; a beat-level reference model predicts every output.

`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 7
`endif

module tb_zeta_addr_gen;

  localparam int BEATS = 1 << (`NTT_STAGE_CNT - 1);

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       stall;
  logic       inv;
  logic       in_ready, in_ready1;
  logic [2:0] rom_addr0, rom_addr1;
  logic [0:0] b_addr0, b_addr1;
  logic       addr_valid, zeta_valid, poly_last, busy;
  logic       b_av, b_zv, b_pl, b_busy;

  int checks = 0;
  int errors = 0;

  zeta_addr_gen #(.STAGE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .inv(inv), .rom_addr0(rom_addr0), .rom_addr1(rom_addr1),
    .addr_valid(addr_valid), .zeta_valid(zeta_valid), .poly_last(poly_last),
    .busy(busy)
  );

  zeta_addr_gen #(.STAGE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .stall(stall), .inv(inv), .rom_addr0(b_addr0), .rom_addr1(b_addr1),
    .addr_valid(b_av), .zeta_valid(b_zv), .poly_last(b_pl), .busy(b_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: zeta index of butterfly b in a stage with 2^stage zetas
  // is floor(b * 2^stage / (2*BEATS)); inverse reads the ROM back to front.
  function automatic int exp_addr(int k, bit inv_b, int lane, int stage);
    int n;
    int b;
    int f;
    n = 1 << stage;
    b = k + lane * BEATS;
    f = (b * n) / (2 * BEATS);
    return inv_b ? (n - 1 - f) : f;
  endfunction

  int         m_beat;
  bit         m_inv;
  logic [2:0] e_a0, e_a1;
  logic [0:0] e_b0, e_b1;
  logic       e_av, e_last, e_zv, e_pl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_beat <= 0;
      m_inv  <= 1'b0;
      e_a0   <= '0;
      e_a1   <= '0;
      e_b0   <= '0;
      e_b1   <= '0;
      e_av   <= 1'b0;
      e_last <= 1'b0;
      e_zv   <= 1'b0;
      e_pl   <= 1'b0;
    end else begin
      e_zv <= e_av;
      e_pl <= e_av && e_last;
      if (in_valid && !stall) begin
        e_av   <= 1'b1;
        e_last <= (m_beat == BEATS - 1);
        e_a0   <= 3'(exp_addr(m_beat, (m_beat == 0) ? inv : m_inv, 0, 3));
        e_a1   <= 3'(exp_addr(m_beat, (m_beat == 0) ? inv : m_inv, 1, 3));
        e_b0   <= 1'(exp_addr(m_beat, (m_beat == 0) ? inv : m_inv, 0, 1));
        e_b1   <= 1'(exp_addr(m_beat, (m_beat == 0) ? inv : m_inv, 1, 1));
        if (m_beat == 0) m_inv <= inv;
        m_beat <= (m_beat + 1) % BEATS;
      end else begin
        e_av <= 1'b0;
      end
    end
  end

  // driver: advance one clock and settle past the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; stall = 1'b0; inv = 1'b1;
    #3;
    checks++;
    if ({rom_addr0, rom_addr1, addr_valid, zeta_valid, poly_last, busy} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {rom_addr0, rom_addr1, addr_valid, zeta_valid, poly_last, busy});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_nostall: got %b required 1", in_ready); end
    cycle();
    stall = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_stall: got %b required 0", in_ready); end
    cycle();
    checks++;
    if ({b_addr0, b_addr1, b_av, b_zv, b_pl, b_busy} !== 6'd0) begin
      errors++; $display("FAIL reset_outputs_s1: got %b required 0", {b_addr0, b_addr1, b_av, b_zv, b_pl, b_busy});
    end
    in_valid = 1'b0; stall = 1'b0; inv = 1'b0;
    rst_n = 1'b1;
    cycle();
  endtask

  // 64 back-to-back beats with fixed inv; cycle 1 is the first accept cycle
  task automatic test_pattern(input bit inv_b);
    int z;
    in_valid = 1'b1; stall = 1'b0; inv = inv_b;
    for (int c = 1; c <= 68; c++) begin
      cycle();
      if (c == BEATS) in_valid = 1'b0;
      checks++;
      if ({rom_addr0, rom_addr1, addr_valid, zeta_valid, poly_last} !== {e_a0, e_a1, e_av, e_zv, e_pl}) begin
        errors++;
        $display("FAIL pattern_model inv=%0d c=%0d: got a0=%0d a1=%0d av=%b zv=%b pl=%b required a0=%0d a1=%0d av=%b zv=%b pl=%b",
                 inv_b, c, rom_addr0, rom_addr1, addr_valid, zeta_valid, poly_last, e_a0, e_a1, e_av, e_zv, e_pl);
      end
      checks++;
      if (busy !== (m_beat != 0)) begin errors++; $display("FAIL pattern_busy c=%0d: got %b required %b", c, busy, m_beat != 0); end
      checks++;
      if ({b_addr0, b_addr1} !== {e_b0, e_b1}) begin
        errors++; $display("FAIL pattern_s1 c=%0d: got %b%b required %b%b", c, b_addr0, b_addr1, e_b0, e_b1);
      end
      checks++;
      if (poly_last !== (c == 65)) begin errors++; $display("FAIL poly_last_cycle c=%0d: got %b required %b", c, poly_last, c == 65); end
      if (c <= BEATS) begin
        z = (c - 1) / 16;
        checks++;
        if (int'(rom_addr0) != (inv_b ? 7 - z : z) || int'(rom_addr1) != (inv_b ? 3 - z : 4 + z)) begin
          errors++;
          $display("FAIL pattern_const c=%0d: got %0d/%0d required %0d/%0d", c, rom_addr0, rom_addr1,
                   inv_b ? 7 - z : z, inv_b ? 3 - z : 4 + z);
        end
        checks++;
        if ({b_addr0, b_addr1} !== (inv_b ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL s1_const c=%0d: got %b%b", c, b_addr0, b_addr1);
        end
      end
    end
    inv = 1'b0;
  endtask

  task automatic test_stall();
    in_valid = 1'b1; stall = 1'b0; inv = 1'b0;
    for (int c = 0; c <= 20; c++) cycle();
    stall = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
    for (int s = 0; s < 5; s++) begin
      cycle();
      checks++;
      if (int'(rom_addr0) != 1 || int'(rom_addr1) != 5 || addr_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold s=%0d: got a=%0d/%0d av=%b busy=%b rdy=%b required a=1/5 av=0 busy=1 rdy=0",
                 s, rom_addr0, rom_addr1, addr_valid, busy, in_ready);
      end
    end
    stall = 1'b0;
    cycle();
    checks++;
    if (int'(rom_addr0) != 1 || int'(rom_addr1) != 5 || addr_valid !== 1'b1 || m_beat != 22) begin
      errors++; $display("FAIL stall_resume: got a=%0d/%0d av=%b model_next=%0d required a=1/5 av=1 next=22", rom_addr0, rom_addr1, addr_valid, m_beat);
    end
    for (int c = 22; c < BEATS; c++) begin
      cycle();
      checks++;
      if ({rom_addr0, rom_addr1, addr_valid} !== {e_a0, e_a1, e_av}) begin
        errors++; $display("FAIL stall_tail beat=%0d: got %0d/%0d/%b required %0d/%0d/%b", c, rom_addr0, rom_addr1, addr_valid, e_a0, e_a1, e_av);
      end
    end
    in_valid = 1'b0;
    cycle(); cycle(); cycle();
    checks++;
    if (busy !== 1'b0 || poly_last !== 1'b0) begin errors++; $display("FAIL stall_drain: got busy=%b pl=%b required 0 0", busy, poly_last); end
  endtask

  // 128 back-to-back beats; inv rises at beat 30 and only affects poly 2
  task automatic test_back_to_back();
    int pl_cnt;
    pl_cnt = 0;
    in_valid = 1'b1; stall = 1'b0; inv = 1'b0;
    for (int c = 1; c <= 2 * BEATS; c++) begin
      cycle();
      if (c == 30) inv = 1'b1;
      if (poly_last) pl_cnt++;
      checks++;
      if (addr_valid !== 1'b1 || {rom_addr0, rom_addr1} !== {e_a0, e_a1}) begin
        errors++; $display("FAIL b2b c=%0d: got %0d/%0d av=%b required %0d/%0d av=1", c, rom_addr0, rom_addr1, addr_valid, e_a0, e_a1);
      end
      if (c > 30 && c <= BEATS) begin
        checks++;
        if (int'(rom_addr0) != (c - 1) / 16) begin
          errors++; $display("FAIL inv_ignored c=%0d: got %0d required %0d", c, rom_addr0, (c - 1) / 16);
        end
      end
      if (c == BEATS + 1) begin
        checks++;
        if (int'(rom_addr0) != 7 || int'(rom_addr1) != 3) begin
          errors++; $display("FAIL second_poly_start: got %0d/%0d required 7/3", rom_addr0, rom_addr1);
        end
      end
    end
    in_valid = 1'b0; inv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (poly_last) pl_cnt++;
    end
    checks++;
    if (pl_cnt != 2) begin errors++; $display("FAIL b2b_poly_last_count: got %0d required 2", pl_cnt); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; stall = 1'b0; inv = 1'b0;
    for (int c = 0; c < 40; c++) cycle();
    #2;
    rst_n = 1'b0;
    stall = 1'b1;
    #1;
    checks++;
    if ({rom_addr0, rom_addr1, addr_valid, zeta_valid, poly_last, busy, b_addr0, b_addr1, b_busy} !== 13'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %b required 0",
                         {rom_addr0, rom_addr1, addr_valid, zeta_valid, poly_last, busy, b_addr0, b_addr1, b_busy});
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_in_ready: got %b required 0", in_ready); end
    cycle(); cycle();
    stall = 1'b0;
    rst_n = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (int'(rom_addr0) != 0 || int'(rom_addr1) != 4 || addr_valid !== 1'b1 || {b_addr0, b_addr1} !== 2'b01) begin
      errors++; $display("FAIL reset_mid_first: got %0d/%0d av=%b s1=%b%b required 0/4 av=1 s1=01",
                         rom_addr0, rom_addr1, addr_valid, b_addr0, b_addr1);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      inv      = $urandom_range(0, 1) != 0;
      #1;
      checks++;
      if (in_ready !== !stall || in_ready1 !== !stall) begin
        errors++; $display("FAIL rand_in_ready c=%0d: got %b/%b required %b", c, in_ready, in_ready1, !stall);
      end
      cycle();
      checks++;
      if ({rom_addr0, rom_addr1, addr_valid, zeta_valid, poly_last, busy} !== {e_a0, e_a1, e_av, e_zv, e_pl, m_beat != 0}) begin
        errors++;
        $display("FAIL rand_s3 c=%0d: got %0d/%0d av=%b zv=%b pl=%b busy=%b required %0d/%0d av=%b zv=%b pl=%b busy=%b",
                 c, rom_addr0, rom_addr1, addr_valid, zeta_valid, poly_last, busy, e_a0, e_a1, e_av, e_zv, e_pl, m_beat != 0);
      end
      checks++;
      if ({b_addr0, b_addr1, b_av, b_zv, b_pl, b_busy} !== {e_b0, e_b1, e_av, e_zv, e_pl, m_beat != 0}) begin
        errors++;
        $display("FAIL rand_s1 c=%0d: got %b%b %b%b%b%b required %b%b %b%b%b%b", c, b_addr0, b_addr1, b_av, b_zv, b_pl, b_busy,
                 e_b0, e_b1, e_av, e_zv, e_pl, m_beat != 0);
      end
    end
    in_valid = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; inv = 1'b0;
    test_reset();
    test_pattern(1'b0);
    test_pattern(1'b1);
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
